sparse_decompress_vector: RTL



---
 rtl/sparse_decompress_vector_pkg.sv | 29 ++
 rtl/sparse_decompress_vector.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/sparse_decompress_vector_pkg.sv
// Shared types for the zero-run-length decoder: FSM state encoding and compressed entry layout.
package sparse_decompress_vector_pkg;

`ifndef BITS_OF_INDICES
`define BITS_OF_INDICES 4
`endif
`ifndef MAX_SIZE_OUTPUT
`define MAX_SIZE_OUTPUT 8
`endif

  localparam int unsigned CE_DATA_W = 16;
  localparam int unsigned CE_IDX_W  = `BITS_OF_INDICES;
  localparam int unsigned CE_LEN_W  = `MAX_SIZE_OUTPUT;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    ZERO,
    VAL,
    PAD
  } state_t;

  typedef struct packed {
    logic [CE_DATA_W-1:0] data;
    logic [CE_IDX_W-1:0]  run;
    logic                 last;
  } entry_t;

endpackage

// File: rtl/sparse_decompress_vector.sv
// Expands (value, zero-run) entries into a dense vector of cfg_len elements.
// Optional SPARSE_DECOMP_POS_OUT_EN adds out_pos, each element's dense coordinate.
module sparse_decompress_vector
    import sparse_decompress_vector_pkg::*;
#(
    parameter int unsigned DATA_W = CE_DATA_W,
    parameter int unsigned IDX_W  = CE_IDX_W,
    parameter int unsigned LEN_W  = CE_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [IDX_W-1:0]  in_run,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
`ifdef SPARSE_DECOMP_POS_OUT_EN
    output logic [LEN_W-1:0]  out_pos,
`endif
    output logic              err_overflow
);

    state_t            r_state;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  r_pos;
    logic [IDX_W-1:0]  r_run;
    logic [DATA_W-1:0] r_val;
    logic              r_last;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              r_done;
    logic              r_err;
`ifdef SPARSE_DECOMP_POS_OUT_EN
    logic [LEN_W-1:0]  r_out_pos;
`endif

    logic              w_load_en;
    logic              w_ovf;
    logic              w_step;
    logic              w_emit;
    logic              w_at_end;
    logic              w_more;
    logic [DATA_W-1:0] w_emit_data;

    // Once pos reaches len it stays there; such elements are consumed without a free output slot.
    assign w_load_en   = !r_out_valid || out_ready;
    assign w_ovf       = (r_pos >= r_len);
    assign w_step      = w_ovf || w_load_en;
    assign w_emit      = w_step && (r_state == ZERO || r_state == VAL || r_state == PAD);
    assign w_at_end    = (r_pos == r_len - LEN_W'(1));
    assign w_more      = ({1'b0, r_pos} + (LEN_W+1)'(1)) < {1'b0, r_len};
    assign w_emit_data = (r_state == VAL) ? r_val : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len       <= '0;
            r_pos       <= '0;
            r_run       <= '0;
            r_val       <= '0;
            r_last      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef SPARSE_DECOMP_POS_OUT_EN
            r_out_pos   <= '0;
`endif
        end else begin
            r_done <= r_out_valid && out_ready && r_out_last;
            if (w_load_en) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len   <= (cfg_len == '0) ? LEN_W'(1) : cfg_len;
                        r_pos   <= '0;
                        r_err   <= 1'b0;
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        r_val   <= in_data;
                        r_run   <= in_run;
                        r_last  <= in_last;
                        r_state <= (in_run != '0) ? ZERO : VAL;
                    end
                end
                ZERO: begin
                    if (w_step) begin
                        r_run <= r_run - IDX_W'(1);
                        if (r_run == IDX_W'(1)) begin
                            r_state <= VAL;
                        end
                    end
                end
                VAL: begin
                    if (w_step) begin
                        if (r_last) begin
                            r_state <= w_more ? PAD : IDLE;
                        end else begin
                            r_state <= FETCH;
                        end
                    end
                end
                PAD: begin
                    if (w_step && (w_at_end || w_ovf)) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            if (w_emit) begin
                if (w_ovf) begin
                    r_err <= 1'b1;
                end else begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_emit_data;
                    r_out_last  <= w_at_end;
                    r_pos       <= r_pos + LEN_W'(1);
`ifdef SPARSE_DECOMP_POS_OUT_EN
                    r_out_pos   <= r_pos;
`endif
                end
            end
        end
    end

    assign in_ready     = (r_state == FETCH);
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;
    assign out_last     = r_out_last;
    assign done         = r_done;
    assign err_overflow = r_err;
`ifdef SPARSE_DECOMP_POS_OUT_EN
    assign out_pos      = r_out_pos;
`endif

endmodule
